// File: rtl/hub75_pkg.sv
// Shared types for the HUB75 BCM scanner: controller states and the bit-plane index.
package hub75_pkg;

  localparam int PLANES = 6;

  typedef logic [2:0] plane_t;

  localparam plane_t PLANE_TOP = plane_t'(PLANES - 1);

  typedef enum logic [2:0] {
    IDLE,
    PREFETCH,
    SHIFT,
    LATCH,
    DISPLAY,
    BLANK
  } state_t;

endpackage

// File: rtl/bcm_plane_timer.sv
// Display-time down counter: loads BASE_TICKS<<plane and flags the last on-time cycle.
module bcm_plane_timer
  import hub75_pkg::*;
#(
  parameter int BASE_TICKS = 8,
  parameter int CNT_W      = $clog2(BASE_TICKS << 5) + 1
) (
  input  logic   clk_root,
  input  logic   reset_n,
  input  logic   load,
  input  logic   run,
  input  plane_t plane,
  output logic   done
);

  logic [CNT_W-1:0] cnt;

  // Counts T..1 while running, so the display lasts exactly T cycles.
  always_ff @(posedge clk_root or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_W'(BASE_TICKS) << plane;
    end else if (run && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == CNT_W'(1));

endmodule

// File: rtl/hub75_bcm_scan.sv
// HUB75 panel driver using binary-code modulation, planes 5..0 per row.
// Optional macro BCM_DEADTIME_EN stretches the post-display blank to DEADTIME_CYCLES.
module hub75_bcm_scan
  import hub75_pkg::*;
#(
  parameter int PIXEL_WIDTH     = 64,
  parameter int ROWS            = 16,
  parameter int BASE_TICKS      = 8,
  parameter int DEADTIME_CYCLES = 4
) (
  input  logic                           clk_root,
  input  logic                           reset_n,
  input  logic                           enable,
  output logic                           rd_en,
  output logic [$clog2(PIXEL_WIDTH)-1:0] rd_col,
  output logic [$clog2(ROWS)-1:0]        rd_row,
  input  logic [5:0]                     red_top,
  input  logic [5:0]                     green_top,
  input  logic [5:0]                     blue_top,
  input  logic [5:0]                     red_bot,
  input  logic [5:0]                     green_bot,
  input  logic [5:0]                     blue_bot,
  output logic                           hub75_clk,
  output logic                           hub75_latch,
  output logic                           hub75_oe_n,
  output logic [2:0]                     hub75_rgb1,
  output logic [2:0]                     hub75_rgb2,
  output logic [$clog2(ROWS)-1:0]        hub75_addr,
  output logic                           frame_done
);

  localparam int COL_W = $clog2(PIXEL_WIDTH);
  localparam int ROW_W = $clog2(ROWS);

`ifdef BCM_DEADTIME_EN
  localparam int BLANK_CYCLES = DEADTIME_CYCLES;
`else
  // Single-cycle blank; DEADTIME_CYCLES has no effect in this build.
  localparam int BLANK_CYCLES = 1 + 0 * DEADTIME_CYCLES;
`endif

  localparam int BLK_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

  state_t           state, state_nxt;
  plane_t           plane, plane_nxt;
  logic [ROW_W-1:0] row, row_nxt;
  logic [COL_W-1:0] col, col_nxt;
  logic             ph, ph_nxt;
  logic [BLK_W-1:0] blank_cnt;
  logic             blank_last;
  logic             timer_done;

  logic             rd_en_nxt, clk_nxt, latch_nxt, oe_n_nxt, frame_nxt;
  logic [COL_W-1:0] rd_col_nxt;
  logic [ROW_W-1:0] rd_row_nxt, addr_nxt;

  bcm_plane_timer #(
    .BASE_TICKS(BASE_TICKS)
  ) u_timer (
    .clk_root(clk_root),
    .reset_n (reset_n),
    .load    (state == LATCH),
    .run     (state == DISPLAY),
    .plane   (plane),
    .done    (timer_done)
  );

  always_ff @(posedge clk_root or negedge reset_n) begin
    if (!reset_n) begin
      blank_cnt <= '0;
    end else if ((state == BLANK) && !blank_last) begin
      blank_cnt <= blank_cnt + 1'b1;
    end else begin
      blank_cnt <= '0;
    end
  end

  assign blank_last = (blank_cnt == BLK_W'(BLANK_CYCLES - 1));

  always_comb begin
    state_nxt  = state;
    plane_nxt  = plane;
    row_nxt    = row;
    col_nxt    = col;
    ph_nxt     = ph;
    rd_en_nxt  = 1'b0;
    rd_col_nxt = rd_col;
    rd_row_nxt = rd_row;
    clk_nxt    = 1'b0;
    latch_nxt  = 1'b0;
    oe_n_nxt   = 1'b1;
    addr_nxt   = hub75_addr;
    frame_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          state_nxt  = PREFETCH;
          rd_en_nxt  = 1'b1;
          rd_col_nxt = '0;
          rd_row_nxt = row;
        end
      end
      PREFETCH: begin
        state_nxt = SHIFT;
        col_nxt   = '0;
        ph_nxt    = 1'b0;
      end
      SHIFT: begin
        if (!ph) begin
          ph_nxt  = 1'b1;
          clk_nxt = 1'b1;
          if (col != COL_W'(PIXEL_WIDTH - 1)) begin
            rd_en_nxt  = 1'b1;
            rd_col_nxt = col + 1'b1;
          end
        end else if (col == COL_W'(PIXEL_WIDTH - 1)) begin
          state_nxt = LATCH;
          latch_nxt = 1'b1;
          addr_nxt  = row;
        end else begin
          col_nxt = col + 1'b1;
          ph_nxt  = 1'b0;
        end
      end
      LATCH: begin
        state_nxt = DISPLAY;
        oe_n_nxt  = 1'b0;
      end
      DISPLAY: begin
        if (timer_done) begin
          state_nxt = BLANK;
        end else begin
          oe_n_nxt = 1'b0;
        end
      end
      BLANK: begin
        if (blank_last) begin
          if (plane != '0) begin
            plane_nxt = plane - 1'b1;
          end else begin
            plane_nxt = PLANE_TOP;
            row_nxt   = row + 1'b1;
            frame_nxt = (row == ROW_W'(ROWS - 1));
          end
          // enable is only honoured here, so a started plane always finishes.
          if (enable) begin
            state_nxt  = PREFETCH;
            rd_en_nxt  = 1'b1;
            rd_col_nxt = '0;
            rd_row_nxt = row_nxt;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_root or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      plane       <= PLANE_TOP;
      row         <= '0;
      col         <= '0;
      ph          <= 1'b0;
      rd_en       <= 1'b0;
      rd_col      <= '0;
      rd_row      <= '0;
      hub75_clk   <= 1'b0;
      hub75_latch <= 1'b0;
      hub75_oe_n  <= 1'b1;
      hub75_addr  <= '0;
      hub75_rgb1  <= '0;
      hub75_rgb2  <= '0;
      frame_done  <= 1'b0;
    end else begin
      state       <= state_nxt;
      plane       <= plane_nxt;
      row         <= row_nxt;
      col         <= col_nxt;
      ph          <= ph_nxt;
      rd_en       <= rd_en_nxt;
      rd_col      <= rd_col_nxt;
      rd_row      <= rd_row_nxt;
      hub75_clk   <= clk_nxt;
      hub75_latch <= latch_nxt;
      hub75_oe_n  <= oe_n_nxt;
      hub75_addr  <= addr_nxt;
      frame_done  <= frame_nxt;
      // Channel data is valid during ph0 (one cycle after its read strobe).
      if ((state == SHIFT) && !ph) begin
        hub75_rgb1 <= {red_top[plane], green_top[plane], blue_top[plane]};
        hub75_rgb2 <= {red_bot[plane], green_bot[plane], blue_bot[plane]};
      end
    end
  end

endmodule

// File: tb/tb_hub75_bcm_scan.sv
// Bench for hub75_bcm_scan: table of pixel vectors, read-strobe scoreboard, timing monitors.
module tb_hub75_bcm_scan;

  localparam int PW = 4;
  localparam int NR = 2;
  localparam int BT = 2;
  localparam int DT = 4;
`ifdef BCM_DEADTIME_EN
  localparam int ROW_PERIOD = 210;
`else
  localparam int ROW_PERIOD = 192;
`endif

  logic       clk_root = 1'b0;
  logic       reset_n;
  logic       enable;
  logic       rd_en;
  logic [1:0] rd_col;
  logic [0:0] rd_row;
  logic [5:0] red_top = '0, green_top = '0, blue_top = '0;
  logic [5:0] red_bot = '0, green_bot = '0, blue_bot = '0;
  logic       hub75_clk, hub75_latch, hub75_oe_n, frame_done;
  logic [2:0] hub75_rgb1, hub75_rgb2;
  logic [0:0] hub75_addr;

  hub75_bcm_scan #(
    .PIXEL_WIDTH(PW), .ROWS(NR), .BASE_TICKS(BT), .DEADTIME_CYCLES(DT)
  ) dut (
    .clk_root(clk_root), .reset_n(reset_n), .enable(enable),
    .rd_en(rd_en), .rd_col(rd_col), .rd_row(rd_row),
    .red_top(red_top), .green_top(green_top), .blue_top(blue_top),
    .red_bot(red_bot), .green_bot(green_bot), .blue_bot(blue_bot),
    .hub75_clk(hub75_clk), .hub75_latch(hub75_latch), .hub75_oe_n(hub75_oe_n),
    .hub75_rgb1(hub75_rgb1), .hub75_rgb2(hub75_rgb2), .hub75_addr(hub75_addr),
    .frame_done(frame_done)
  );

  always #5 clk_root = ~clk_root;

  // Pixel inputs and expected {r,g,b} per plane, packed {p5,p4,p3,p2,p1,p0}.
  typedef struct packed {
    logic [5:0]  rt, gt, bt, rb, gb, bb;
    logic [17:0] e1, e2;
  } vec_t;

  vec_t       tbl [5];
  int         cur = 0;
  int         n_pass = 0, n_chk = 0;
  int         exp_oe [6] = '{64, 32, 16, 8, 4, 2};
  logic [5:0] sb_q [$];
  int         n_pop = 0;
  int         latch_total = 0;
  int         cyc = 0, oe_run = 0, n_fd = 0;
  int         last_p5 = -1, last_fd = -1;
  logic       mon_on = 1'b0, timing_on = 1'b1;
  logic [0:0] addr_q = '0;

  function automatic void chk(string nm, longint act, longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endfunction

  // Upstream framebuffer + scaler: one-cycle latency, odd columns return inverted data.
  always @(posedge clk_root) begin
    if (rd_en) begin
      red_top   <= rd_col[0] ? ~tbl[cur].rt : tbl[cur].rt;
      green_top <= rd_col[0] ? ~tbl[cur].gt : tbl[cur].gt;
      blue_top  <= rd_col[0] ? ~tbl[cur].bt : tbl[cur].bt;
      red_bot   <= rd_col[0] ? ~tbl[cur].rb : tbl[cur].rb;
      green_bot <= rd_col[0] ? ~tbl[cur].gb : tbl[cur].gb;
      blue_bot  <= rd_col[0] ? ~tbl[cur].bb : tbl[cur].bb;
    end
  end

  always @(negedge clk_root) begin
    int p;
    logic [5:0] e;
    cyc++;
    if (mon_on) begin
      if (hub75_clk) begin
        chk("sb_nonempty", (sb_q.size() != 0), 1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          n_pop++;
          chk("rgb_shift", {hub75_rgb1, hub75_rgb2}, e);
        end
      end
      if (rd_en) begin
        p = 5 - (latch_total % 6);
        e = {tbl[cur].e1[p*3 +: 3], tbl[cur].e2[p*3 +: 3]};
        if (rd_col[0]) e = ~e;
        sb_q.push_back(e);
        if (rd_col == 2'd0) chk("rd_row", rd_row, (latch_total / 6) % NR);
      end
      if (!hub75_oe_n) oe_run++;
      else if (oe_run > 0) begin
        chk("oe_run", oe_run, exp_oe[(latch_total - 1) % 6]);
        oe_run = 0;
      end
      if (hub75_addr != addr_q) begin
        chk("addr_chg_oe_n", hub75_oe_n, 1);
        chk("addr_chg_p5_latch", {hub75_latch, (latch_total % 6) == 0}, 2'b11);
        chk("addr_value", hub75_addr, (latch_total / 6) % NR);
      end
      addr_q = hub75_addr;
      if (frame_done) begin
        chk("frame_at_wrap", latch_total % (6 * NR), 0);
        if (timing_on && last_fd >= 0) chk("frame_period", cyc - last_fd, NR * ROW_PERIOD);
        last_fd = cyc;
        n_fd++;
      end
      if (hub75_latch) begin
        if (timing_on && (latch_total % 6) == 0) begin
          if (last_p5 >= 0) chk("row_period", cyc - last_p5, ROW_PERIOD);
          last_p5 = cyc;
        end
        latch_total++;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int bad;
    tbl[0] = '{6'b100000, 6'b000000, 6'b000001, 6'b000000, 6'b111111, 6'b010101,
               {3'b100, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001},
               {3'b010, 3'b011, 3'b010, 3'b011, 3'b010, 3'b011}};
    tbl[1] = '{6'b111111, 6'b101010, 6'b000000, 6'b000000, 6'b000000, 6'b000000,
               {3'b110, 3'b100, 3'b110, 3'b100, 3'b110, 3'b100}, 18'd0};
    tbl[2] = '{6'b000000, 6'b000000, 6'b000000, 6'b110000, 6'b001100, 6'b000011,
               18'd0, {3'b100, 3'b100, 3'b010, 3'b010, 3'b001, 3'b001}};
    tbl[3] = '{6'b111111, 6'b111111, 6'b111111, 6'b111111, 6'b111111, 6'b111111,
               {6{3'b111}}, {6{3'b111}}};
    tbl[4] = '{6'b010011, 6'b100100, 6'b001000, 6'b100100, 6'b001000, 6'b010011,
               {3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b100},
               {3'b100, 3'b001, 3'b010, 3'b100, 3'b001, 3'b001}};

    cur = 0;
    enable = 1'b1;
    reset_n = 1'b0;
    repeat (3) @(negedge clk_root);
    chk("rst_oe_n", hub75_oe_n, 1);
    chk("rst_latch", hub75_latch, 0);
    chk("rst_clk", hub75_clk, 0);
    chk("rst_addr", hub75_addr, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_rd_col_row", {rd_col, rd_row}, 0);
    chk("rst_rgb", {hub75_rgb1, hub75_rgb2}, 0);
    chk("rst_frame_done", frame_done, 0);

    reset_n = 1'b1;
    mon_on = 1'b1;
    @(negedge clk_root);
    chk("prefetch_rd_en", rd_en, 1);
    chk("prefetch_rd_col", rd_col, 0);

    for (int v = 0; v < 5; v++) begin
      cur = v;
      t = 0;
      while (latch_total < 6 * (v + 1) && t < 400) begin
        @(negedge clk_root);
        t++;
      end
      chk("row_complete", (latch_total >= 6 * (v + 1)), 1);
    end
    chk("frame_pulses", n_fd, 2);

    // Drop enable in the middle of plane 3's on-time.
    timing_on = 1'b0;
    t = 0;
    while (!(!hub75_oe_n && ((latch_total - 1) % 6) == 2) && t < 400) begin
      @(negedge clk_root);
      t++;
    end
    chk("reach_plane3_display", (!hub75_oe_n && ((latch_total - 1) % 6) == 2), 1);
    enable = 1'b0;
    cur = 0;
    t = 0;
    while (!hub75_oe_n && t < 100) begin
      @(negedge clk_root);
      t++;
    end
    @(negedge clk_root);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_root);
      if (rd_en || !hub75_oe_n || hub75_latch || hub75_clk) bad++;
    end
    chk("idle_quiet_cycles_bad", bad, 0);
    chk("idle_sb_empty", sb_q.size(), 0);
    chk("idle_latch_pos", latch_total % 6, 3);

    enable = 1'b1;
    @(negedge clk_root);
    chk("resume_rd_en", rd_en, 1);
    chk("resume_rd_col", rd_col, 0);
    t = 0;
    while (hub75_oe_n && t < 100) begin
      @(negedge clk_root);
      t++;
    end
    chk("resume_display", hub75_oe_n, 0);
    t = 0;
    while (!hub75_oe_n && t < 100) begin
      @(negedge clk_root);
      t++;
    end
    chk("resume_plane2_done", latch_total % 6, 4);
    chk("sb_pops", (n_pop > 100), 1);

    // Asynchronous reset while the panel is lit.
    t = 0;
    while (hub75_oe_n && t < 200) begin
      @(negedge clk_root);
      t++;
    end
    mon_on = 1'b0;
    chk("pre_reset_lit", hub75_oe_n, 0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_oe_n", hub75_oe_n, 1);
    chk("async_rst_addr_rd_en", {hub75_addr, rd_en, hub75_latch}, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
